// File: rtl/hamming_corrector.sv
// Single-bit corrector for Hamming(12,8) check results, with optional scrub write-back.
// Define HAMMING_SCRUB_EN to build the SCRUB state and scrub_req/scrub_ack handshake.
module hamming_corrector #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              check_valid,
    input  logic              valid_normal_write_in,
    input  logic              valid_normal_read_in,
    input  logic [3:0]        synd,
    input  logic [11:0]       enc_data_old_in,
    input  logic [11:0]       D0_enc_in,
    input  logic [11:0]       D1_enc_in,
    input  logic [11:0]       P_in,
    input  logic [ADDR_W-1:0] address_in,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out_is_write,
    output logic              out_is_read,
    output logic [ADDR_W-1:0] out_address,
    output logic [11:0]       out_codeword,
    output logic [7:0]        out_data,
    output logic [11:0]       D0_enc_out,
    output logic [11:0]       D1_enc_out,
    output logic [11:0]       P_out,
    output logic              err_corrected,
    output logic              err_uncorrectable,
    output logic [3:0]        err_pos,
    output logic              scrub_req,
    output logic [ADDR_W-1:0] scrub_addr,
    output logic [11:0]       scrub_data,
    input  logic              scrub_ack,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    output logic              drop_err
);

    // Handshake: a result is taken on a clock edge where check_valid && in_ready
    // and at least one flow flag is set; anything else is not consumed.
    logic        flow_ok;
    logic        accept;
    logic        fix_en;
    logic        unc_en;
    logic [11:0] fixed_cw;
    logic [7:0]  fixed_data;

    assign flow_ok = valid_normal_write_in | valid_normal_read_in;
    assign accept  = check_valid & in_ready & flow_ok;
    assign fix_en  = (synd != 4'd0) && (synd <= 4'd12);
    assign unc_en  = (synd >= 4'd13);

    always_comb begin
        fixed_cw = '0;
        for (int i = 0; i < 12; i++) begin
            fixed_cw[i] = enc_data_old_in[i] ^ (fix_en && (synd == 4'(i + 1)));
        end
    end

    // Data bits sit at Hamming positions 3,5,6,7,9,10,11,12.
    assign fixed_data = {fixed_cw[11], fixed_cw[10], fixed_cw[9], fixed_cw[8],
                         fixed_cw[6],  fixed_cw[5],  fixed_cw[4], fixed_cw[2]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid         <= 1'b0;
            out_is_write      <= 1'b0;
            out_is_read       <= 1'b0;
            out_address       <= '0;
            out_codeword      <= '0;
            out_data          <= '0;
            D0_enc_out        <= '0;
            D1_enc_out        <= '0;
            P_out             <= '0;
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
            err_pos           <= '0;
        end else if (accept) begin
            out_valid         <= 1'b1;
            out_is_write      <= valid_normal_write_in;
            out_is_read       <= valid_normal_read_in & ~valid_normal_write_in;
            out_address       <= address_in;
            out_codeword      <= fixed_cw;
            out_data          <= fixed_data;
            D0_enc_out        <= D0_enc_in;
            D1_enc_out        <= D1_enc_in;
            P_out             <= P_in;
            err_corrected     <= fix_en;
            err_uncorrectable <= unc_en;
            err_pos           <= fix_en ? synd : 4'd0;
        end else begin
            out_valid         <= 1'b0;
            out_is_write      <= 1'b0;
            out_is_read       <= 1'b0;
            out_address       <= '0;
            out_codeword      <= '0;
            out_data          <= '0;
            D0_enc_out        <= '0;
            D1_enc_out        <= '0;
            P_out             <= '0;
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
            err_pos           <= '0;
        end
    end

    // Saturating counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (accept && fix_en && (corr_cnt != '1)) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
            if (accept && unc_en && (uncorr_cnt != '1)) begin
                uncorr_cnt <= uncorr_cnt + 1'b1;
            end
        end
    end

`ifdef HAMMING_SCRUB_EN
    typedef enum logic {IDLE = 1'b0, SCRUB = 1'b1} state_t;
    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && fix_en) state_nxt = SCRUB;
            SCRUB:   if (scrub_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        scrub_req = (state == SCRUB);
    end

    // Captured only when a scrub starts, so they stay stable while scrub_req is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scrub_addr <= '0;
            scrub_data <= '0;
        end else if (accept && fix_en) begin
            scrub_addr <= address_in;
            scrub_data <= fixed_cw;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_err <= 1'b0;
        end else if (check_valid && !in_ready) begin
            drop_err <= 1'b1;
        end
    end
`else
    logic unused_scrub_ack;
    assign unused_scrub_ack = scrub_ack;
    assign in_ready         = 1'b1;
    assign scrub_req        = 1'b0;
    assign scrub_addr       = '0;
    assign scrub_data       = '0;
    assign drop_err         = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_corrector.sv
// Scoreboard bench for hamming_corrector: directed vectors, expected results queued at issue.
module tb_hamming_corrector;

`ifdef HAMMING_SCRUB_EN
    localparam bit SCRUB_EN = 1'b1;
`else
    localparam bit SCRUB_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        check_valid;
    logic        wr_in;
    logic        rd_in;
    logic [3:0]  synd;
    logic [11:0] enc;
    logic [11:0] d0_in, d1_in, p_in;
    logic [7:0]  addr_in;
    logic        in_ready;
    logic        out_valid;
    logic        out_is_write, out_is_read;
    logic [7:0]  out_address;
    logic [11:0] out_codeword;
    logic [7:0]  out_data;
    logic [11:0] d0_out, d1_out, p_out;
    logic        err_corrected, err_uncorrectable;
    logic [3:0]  err_pos;
    logic        scrub_req;
    logic [7:0]  scrub_addr;
    logic [11:0] scrub_data;
    logic        scrub_ack;
    logic        cnt_clr;
    logic [7:0]  corr_cnt, uncorr_cnt;
    logic        drop_err;

    int checks   = 0;
    int failures = 0;
    logic [71:0] exp_q[$];

    hamming_corrector #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .check_valid(check_valid),
        .valid_normal_write_in(wr_in), .valid_normal_read_in(rd_in),
        .synd(synd), .enc_data_old_in(enc),
        .D0_enc_in(d0_in), .D1_enc_in(d1_in), .P_in(p_in), .address_in(addr_in),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_is_write(out_is_write), .out_is_read(out_is_read),
        .out_address(out_address), .out_codeword(out_codeword), .out_data(out_data),
        .D0_enc_out(d0_out), .D1_enc_out(d1_out), .P_out(p_out),
        .err_corrected(err_corrected), .err_uncorrectable(err_uncorrectable),
        .err_pos(err_pos), .scrub_req(scrub_req), .scrub_addr(scrub_addr),
        .scrub_data(scrub_data), .scrub_ack(scrub_ack), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .drop_err(drop_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] pack(input logic w, r, input logic [7:0] a,
                                         input logic [11:0] cw, input logic [7:0] d,
                                         input logic c, u, input logic [3:0] pos,
                                         input logic [11:0] s0, s1, sp);
        return {w, r, a, cw, d, c, u, pos, s0, s1, sp};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drivers: inputs change on the falling edge, the DUT samples on the rising edge.
    task automatic send(input logic w, r, input logic [3:0] s, input logic [11:0] e,
                        input logic [7:0] a, input logic [11:0] ecw, input logic [7:0] edata,
                        input logic [3:0] epos, input logic eunc, input logic accepted);
        @(negedge clk);
        check_valid = 1'b1;
        wr_in = w;
        rd_in = r;
        synd = s;
        enc = e;
        addr_in = a;
        d0_in = {4'h1, a};
        d1_in = {4'h2, a};
        p_in = {4'h3, a};
        if (accepted)
            exp_q.push_back(pack(w, r & ~w, a, ecw, edata, epos != 4'd0, eunc, epos,
                                 {4'h1, a}, {4'h2, a}, {4'h3, a}));
    endtask

    task automatic idle();
        @(negedge clk);
        check_valid = 1'b0;
        wr_in = 1'b0;
        rd_in = 1'b0;
        synd = 4'd0;
        enc = 12'h000;
        cnt_clr = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a result is presented.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out: got out_valid=1 addr=0x%0h expected no result", out_address);
            end else begin
                logic [71:0] exp_v;
                logic [71:0] act_v;
                exp_v = exp_q.pop_front();
                act_v = pack(out_is_write, out_is_read, out_address, out_codeword, out_data,
                             err_corrected, err_uncorrectable, err_pos, d0_out, d1_out, p_out);
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL result: got 0x%018h expected 0x%018h", act_v, exp_v);
                end
            end
        end
    end

    initial begin
        #200000;
        checks++;
        failures++;
        $display("FAIL timeout: got no end of test expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset = 1'b0;
        check_valid = 1'b0;
        wr_in = 1'b0; rd_in = 1'b0;
        synd = 4'd0; enc = 12'h000;
        d0_in = 12'h000; d1_in = 12'h000; p_in = 12'h000;
        addr_in = 8'h00;
        scrub_ack = 1'b0;
        cnt_clr = 1'b0;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_scrub_req", scrub_req, 0);
        check("rst_corr_cnt", corr_cnt, 0);
        check("rst_drop_err", drop_err, 0);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back clean reads
        send(0, 1, 4'd0, 12'hF77, 8'h11, 12'hF77, 8'hFF, 4'd0, 0, 1);
        send(0, 1, 4'd0, 12'h5A5, 8'h12, 12'h5A5, 8'h55, 4'd0, 0, 1);
        idle();
        check("clean_scrub_req", scrub_req, 0);
        check("clean_in_ready", in_ready, 1);
        idle();
        check("clean_corr_cnt", corr_cnt, 0);

        // Correctable read, then a second result while the scrub is pending
        send(0, 1, 4'd5, 12'h010, 8'h3A, 12'h000, 8'h00, 4'd5, 0, 1);
        idle();
        check("corr_cnt_1", corr_cnt, 1);
        if (SCRUB_EN) begin
            check("scrub_req_up", scrub_req, 1);
            check("scrub_addr", scrub_addr, 32'h3A);
            check("scrub_data", scrub_data, 32'h000);
            check("scrub_in_ready", in_ready, 0);
        end
        idle();
        send(0, 1, 4'd0, 12'h0F0, 8'h40, 12'h0F0, 8'h0E, 4'd0, 0, !SCRUB_EN);
        idle();
        check("drop_err", drop_err, SCRUB_EN);
        if (SCRUB_EN) begin
            check("scrub_req_held", scrub_req, 1);
            check("scrub_addr_held", scrub_addr, 32'h3A);
        end
        @(negedge clk);
        scrub_ack = 1'b1;
        @(negedge clk);
        scrub_ack = 1'b0;
        check("scrub_req_done", scrub_req, 0);
        check("ready_after_ack", in_ready, 1);

        // Uncorrectable with both flags: tagged as write
        send(1, 1, 4'd14, 12'hABC, 8'h55, 12'hABC, 8'hA7, 4'd0, 1, 1);
        idle();
        check("uncorr_cnt_1", uncorr_cnt, 1);
        check("uncorr_no_scrub", scrub_req, 0);

        // No flow flag: ignored
        send(0, 0, 4'd5, 12'h010, 8'h77, 12'h000, 8'h00, 4'd5, 0, 0);
        idle();
        idle();
        check("noflag_corr_cnt", corr_cnt, 1);

        // Syndrome boundaries 12, 1 and 13
        scrub_ack = 1'b1;
        send(0, 1, 4'd12, 12'h800, 8'h60, 12'h000, 8'h00, 4'd12, 0, 1);
        idle();
        send(0, 1, 4'd1, 12'h001, 8'h61, 12'h000, 8'h00, 4'd1, 0, 1);
        idle();
        send(1, 0, 4'd13, 12'h123, 8'h62, 12'h123, 8'h14, 4'd0, 1, 1);
        idle();
        check("bound_corr_cnt", corr_cnt, 3);
        check("bound_uncorr_cnt", uncorr_cnt, 2);

        // Saturation
        for (int i = 0; i < 260; i++) begin
            send(0, 1, 4'd3, 12'h004, 8'(i), 12'h000, 8'h00, 4'd3, 0, 1);
            idle();
        end
        check("corr_cnt_sat", corr_cnt, 255);
        send(0, 1, 4'd3, 12'h004, 8'hF0, 12'h000, 8'h00, 4'd3, 0, 1);
        cnt_clr = 1'b1;
        idle();
        check("clr_corr_cnt", corr_cnt, 0);
        check("clr_uncorr_cnt", uncorr_cnt, 0);
        idle();
        send(0, 1, 4'd3, 12'h004, 8'hF1, 12'h000, 8'h00, 4'd3, 0, 1);
        idle();
        check("after_clr_cnt", corr_cnt, 1);

        // Reset while a scrub is pending
        idle();
        scrub_ack = 1'b0;
        send(0, 1, 4'd7, 12'h040, 8'h99, 12'h000, 8'h00, 4'd7, 0, 1);
        idle();
        check("pre_rst_scrub_req", scrub_req, SCRUB_EN);
        #2;
        reset = 1'b0;
        #1;
        check("async_scrub_req", scrub_req, 0);
        check("async_out_valid", out_valid, 0);
        check("async_in_ready", in_ready, 1);
        check("async_corr_cnt", corr_cnt, 0);
        check("async_drop_err", drop_err, 0);
        check("async_scrub_addr", scrub_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_scrub_req", scrub_req, 0);

        idle();
        idle();
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hamming_corrector.md
# hamming_corrector

Single-bit error corrector placed directly downstream of the Hamming(12,8) syndrome checker in the SSD-RAID datapath. It consumes each registered check result: codeword, 4-bit syndrome, D0/D1/P stripes, address and read/write tag. It produces a corrected codeword, the decoded data byte and error flags for the read/write controllers. Optionally it issues a scrub write-back of corrected codewords to storage over a req/ack handshake, and keeps saturating error statistics.

## Interface
Parameters:
- ADDR_W, 8, address width
- CNT_W, 8, error counter width

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- check_valid  input  1  one-cycle pulse; the check result inputs are valid
- valid_normal_write_in  input  1  result belongs to a write (read-modify-write) flow
- valid_normal_read_in  input  1  result belongs to a normal read
- synd  input  4  syndrome {S4,S3,S2,S1}
- enc_data_old_in  input  12  codeword that was checked
- D0_enc_in, D1_enc_in, P_in  input  12 each  stripe pass-through
- address_in  input  ADDR_W  target address
- in_ready  output  1  high when a new check result can be accepted
- out_valid  output  1  one-cycle result pulse
- out_is_write, out_is_read  output  1 each  flow tag
- out_address  output  ADDR_W  registered address
- out_codeword  output  12  corrected codeword
- out_data  output  8  decoded byte
- D0_enc_out, D1_enc_out, P_out  output  12 each  registered stripes
- err_corrected  output  1  single-bit error fixed (valid with out_valid)
- err_uncorrectable  output  1  syndrome 13..15 (valid with out_valid)
- err_pos  output  4  syndrome value of the corrected bit, 0 if none
- scrub_req  output  1  scrub write request
- scrub_addr  output  ADDR_W  scrub target
- scrub_data  output  12  corrected codeword to write back
- scrub_ack  input  1  storage accepted the scrub
- cnt_clr  input  1  synchronous clear of both counters
- corr_cnt, uncorr_cnt  output  CNT_W each  saturating error counters
- drop_err  output  1  sticky: a check_valid arrived while in_ready was low

## Operation
- Codeword bit i is Hamming position i+1. Parity bits are 0, 1, 3, 7. Data bits 2, 4, 5, 6, 8, 9, 10, 11 map to out_data[0..7].
- Syndrome 0: clean; codeword passes unchanged.
- Syndrome 1..12: invert bit synd-1; err_corrected=1; err_pos=synd.
- Syndrome 13..15: uncorrectable; codeword passes uncorrected; err_uncorrectable=1; err_pos=0.
- Tag rules:
  - Both valid flags set: out_is_write=1, out_is_read=0.
  - check_valid with neither flag set: ignored, no output.
- FSM has two states, IDLE and SCRUB.
  - IDLE: in_ready=1. An accepted correctable result goes to SCRUB. Clean and uncorrectable results stay in IDLE.
  - SCRUB: in_ready=0 and scrub_req=1. scrub_addr and scrub_data are held stable. When scrub_ack is sampled high, the next state is IDLE and scrub_req drops.
- check_valid while in_ready=0: the input is discarded, drop_err is set, and the state is unchanged. drop_err is cleared only by reset.
- Counters:
  - corr_cnt increments on err_corrected and uncorr_cnt on err_uncorrectable.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr has priority over a simultaneous increment (result 0).
- scrub_ack while in IDLE is ignored.

## Timing
- Reset values: every output 0 except in_ready=1; FSM in IDLE.
- Latency: check_valid sampled at edge N gives out_valid, data, flags and stripes registered at N+1. They are held one cycle, then return to 0.
- scrub_req rises at N+1, together with out_valid.
  - Minimum scrub duration: scrub_ack high at edge N+1 clears scrub_req after N+2.
  - in_ready is low from N+1 until the cycle after ack.
- Back-to-back clean results are accepted every cycle.
- Reset asserted mid-SCRUB forces IDLE immediately and scrub_req=0 asynchronously. The pending scrub is lost.

## Configuration
- HAMMING_SCRUB_EN defined: the SCRUB state and scrub handshake are as described.
- HAMMING_SCRUB_EN undefined:
  - No SCRUB state.
  - scrub_req, scrub_addr and scrub_data are tied to 0.
  - in_ready is constant 1 and drop_err stays 0.
  - Correction, flags and counters are unchanged.

## Test plan
- Clean read: enc=0xF77, synd=0, read=1 -> next cycle out_data=0xFF, out_codeword=0xF77, no error flags, no scrub_req.
- Correctable read: enc=0x010, synd=5, addr=0x3A -> out_codeword=0x000, out_data=0x00, err_pos=5, corr_cnt=1, scrub_req with scrub_addr=0x3A and scrub_data=0x000 until scrub_ack.
- Uncorrectable write: enc=0xABC, synd=14, write=1 -> err_uncorrectable=1, out_codeword=0xABC, out_is_write=1, uncorr_cnt=1, no scrub.
- Drop: correctable result, then check_valid two cycles later with scrub_ack held low -> second result discarded, drop_err=1, no second out_valid.
- Saturation and clear: 260 syndrome-3 results with scrub_ack tied high -> corr_cnt=255. Then cnt_clr together with a correctable result -> corr_cnt=0.
- Reset mid-scrub: reset low while scrub_req=1 -> scrub_req=0 immediately, in_ready=1 after release, all outputs 0.
